// File: rtl/mod_counter_prog.sv
// Up/down modulo counter (0..mod_active inclusive) with synchronous load and a
// double-buffered run-time modulus that only takes effect at a wrap boundary.
module mod_counter_prog #(
  parameter int          BITS        = 8,
  parameter int unsigned DEF_MOD_MAX = 9
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            up_dn,
  input  logic            load,
  input  logic [BITS-1:0] load_val,
  input  logic            mod_wr,
  input  logic [BITS-1:0] mod_val,
  output logic [BITS-1:0] q,
  output logic            tc,
  output logic            wrap,
  output logic            load_err,
  output logic [BITS-1:0] mod_active,
  output logic            mod_pending
);

  localparam logic [BITS-1:0] DEF_MOD = BITS'(DEF_MOD_MAX);

  logic [BITS-1:0] shadow;
  logic [BITS-1:0] q_next;
  logic [BITS-1:0] mod_next;
  logic [BITS-1:0] load_q;
  logic            load_over;
  logic            at_top;
  logic            at_zero;

  assign at_top    = (q == mod_active);
  assign at_zero   = (q == '0);
  assign tc        = enable & ~load & (up_dn ? at_top : at_zero);
  assign load_over = (load_val > mod_active);
  assign load_q    = load_over ? mod_active : load_val;

  // A write landing on the wrap edge bypasses the shadow entirely.
  assign mod_next  = mod_wr      ? mod_val :
                     mod_pending ? shadow  : mod_active;

  always_comb begin
    q_next = q;
    if (load) begin
      q_next = load_q;
    end else if (enable) begin
      if (up_dn) begin
        q_next = at_top ? '0 : q + BITS'(1);
      end else begin
        q_next = at_zero ? mod_next : q - BITS'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q           <= '0;
      wrap        <= 1'b0;
      load_err    <= 1'b0;
      mod_active  <= DEF_MOD;
      mod_pending <= 1'b0;
      shadow      <= DEF_MOD;
    end else begin
      q        <= q_next;
      wrap     <= tc;
      load_err <= load & load_over;
      if (mod_wr) begin
        shadow <= mod_val;
      end
      if (tc) begin
        mod_active  <= mod_next;
        mod_pending <= 1'b0;
      end else if (mod_wr) begin
        mod_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mod_counter_prog.sv
// Bench for mod_counter_prog: directed scenarios plus randomized traffic
// checked against a cycle-level arithmetic model.
module tb_mod_counter_prog;

  localparam int DEF = 9;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       up_dn;
  logic       load;
  logic [7:0] load_val;
  logic       mod_wr;
  logic [7:0] mod_val;
  logic [7:0] q;
  logic       tc;
  logic       wrap;
  logic       load_err;
  logic [7:0] mod_active;
  logic       mod_pending;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int m_q, m_act, m_sh;
  bit m_pend, m_wrap, m_lerr;

  mod_counter_prog #(.BITS(8), .DEF_MOD_MAX(DEF)) dut (
    .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .load(load),
    .load_val(load_val), .mod_wr(mod_wr), .mod_val(mod_val), .q(q), .tc(tc),
    .wrap(wrap), .load_err(load_err), .mod_active(mod_active),
    .mod_pending(mod_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit model_tc();
    return enable && !load && (up_dn ? (m_q == m_act) : (m_q == 0));
  endfunction

  task automatic set_in(input bit rst, input bit en, input bit ud, input bit ld,
                        input int lv, input bit mw, input int mv);
    reset = rst; enable = en; up_dn = ud; load = ld;
    load_val = 8'(lv); mod_wr = mw; mod_val = 8'(mv);
    #1;
  endtask

  // Advance the model by one edge from the current inputs, then clock the DUT.
  task automatic tick();
    int nq, nact, nsh;
    bit npend, nwrap, nlerr;
    nq = m_q; nact = m_act; nsh = m_sh; npend = m_pend; nwrap = 0; nlerr = 0;
    if (reset) begin
      nq = 0; nact = DEF; nsh = DEF; npend = 0;
    end else begin
      if (load) begin
        nq    = (int'(load_val) < m_act) ? int'(load_val) : m_act;
        nlerr = int'(load_val) > m_act;
      end else if (enable) begin
        if (up_dn) begin
          nq    = (m_q + 1) % (m_act + 1);
          nwrap = (m_q + 1) > m_act;
        end else begin
          nwrap = (m_q == 0);
          nq    = m_q - 1;
        end
      end
      if (nwrap) begin
        if (mod_wr) nact = int'(mod_val);
        else if (m_pend) nact = m_sh;
        npend = 0;
        if (!up_dn) nq = nact;
      end else if (mod_wr) begin
        npend = 1;
      end
      if (mod_wr) nsh = int'(mod_val);
    end
    @(posedge clk);
    #1;
    m_q = nq; m_act = nact; m_sh = nsh; m_pend = npend; m_wrap = nwrap; m_lerr = nlerr;
  endtask

  task automatic do_reset();
    set_in(1, 0, 1, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_reset();
    set_in(0, 1, 1, 0, 0, 1, 3);
    tick();
    tick();
    do_reset();
    n_vec++;
    if (q !== 8'd0 || wrap !== 1'b0 || load_err !== 1'b0 || mod_active !== 8'd9 || mod_pending !== 1'b0) begin
      n_err++;
      $display("FAIL reset: q=%0d wrap=%b lerr=%b act=%0d pend=%b, want 0 0 0 9 0",
               q, wrap, load_err, mod_active, mod_pending);
    end
  endtask

  task automatic test_count_up();
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      set_in(0, 1, 1, 0, 0, 0, 0);
      n_vec++;
      if (tc !== (((i - 1) % 10) == 9)) begin
        n_err++;
        $display("FAIL up_tc step %0d: tc=%b want %b", i, tc, ((i - 1) % 10) == 9);
      end
      tick();
      n_vec++;
      if (q !== 8'(i % 10) || wrap !== ((i % 10) == 0)) begin
        n_err++;
        $display("FAIL up_q step %0d: q=%0d wrap=%b want %0d %b", i, q, wrap, i % 10, (i % 10) == 0);
      end
    end
  endtask

  task automatic test_count_down();
    int exp_q;
    do_reset();
    exp_q = 0;
    for (int i = 1; i <= 12; i++) begin
      set_in(0, 1, 0, 0, 0, 0, 0);
      n_vec++;
      if (tc !== (exp_q == 0)) begin
        n_err++;
        $display("FAIL down_tc step %0d: tc=%b want %b", i, tc, exp_q == 0);
      end
      tick();
      n_vec++;
      if (q !== 8'((exp_q == 0) ? 9 : exp_q - 1) || wrap !== (exp_q == 0)) begin
        n_err++;
        $display("FAIL down_q step %0d: q=%0d wrap=%b want %0d %b", i, q, wrap,
                 (exp_q == 0) ? 9 : exp_q - 1, exp_q == 0);
      end
      exp_q = (exp_q == 0) ? 9 : exp_q - 1;
    end
  endtask

  task automatic test_mod_buffered();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(0, 1, 1, 0, 0, 0, 0);
      tick();
    end
    set_in(0, 1, 1, 0, 0, 1, 4);
    tick();
    n_vec++;
    if (q !== 8'd4 || mod_pending !== 1'b1 || mod_active !== 8'd9) begin
      n_err++;
      $display("FAIL mod_pend: q=%0d pend=%b act=%0d want 4 1 9", q, mod_pending, mod_active);
    end
    for (int i = 0; i < 6; i++) begin
      set_in(0, 1, 1, 0, 0, 0, 0);
      tick();
    end
    n_vec++;
    if (q !== 8'd0 || wrap !== 1'b1 || mod_active !== 8'd4 || mod_pending !== 1'b0) begin
      n_err++;
      $display("FAIL mod_apply: q=%0d wrap=%b act=%0d pend=%b want 0 1 4 0", q, wrap, mod_active, mod_pending);
    end
    for (int i = 1; i <= 5; i++) begin
      set_in(0, 1, 1, 0, 0, 0, 0);
      tick();
      n_vec++;
      if (q !== 8'(i % 5) || wrap !== ((i % 5) == 0)) begin
        n_err++;
        $display("FAIL mod_cycle %0d: q=%0d wrap=%b want %0d %b", i, q, wrap, i % 5, (i % 5) == 0);
      end
    end
  endtask

  task automatic test_mod_bypass();
    do_reset();
    set_in(0, 1, 0, 0, 0, 1, 5);
    n_vec++;
    if (tc !== 1'b1) begin
      n_err++;
      $display("FAIL bypass_tc: tc=%b want 1", tc);
    end
    tick();
    n_vec++;
    if (q !== 8'd5 || mod_active !== 8'd5 || mod_pending !== 1'b0 || wrap !== 1'b1) begin
      n_err++;
      $display("FAIL bypass: q=%0d act=%0d pend=%b wrap=%b want 5 5 0 1", q, mod_active, mod_pending, wrap);
    end
  endtask

  task automatic test_load_clamp();
    do_reset();
    set_in(0, 0, 1, 1, 12, 0, 0);
    tick();
    n_vec++;
    if (q !== 8'd9 || load_err !== 1'b1) begin
      n_err++;
      $display("FAIL load_clamp: q=%0d lerr=%b want 9 1", q, load_err);
    end
    set_in(0, 0, 1, 0, 0, 0, 0);
    tick();
    n_vec++;
    if (q !== 8'd9 || load_err !== 1'b0) begin
      n_err++;
      $display("FAIL load_err_pulse: q=%0d lerr=%b want 9 0", q, load_err);
    end
  endtask

  task automatic test_load_over_enable();
    do_reset();
    set_in(0, 0, 1, 1, 9, 0, 0);
    tick();
    set_in(0, 1, 1, 1, 3, 0, 0);
    n_vec++;
    if (tc !== 1'b0) begin
      n_err++;
      $display("FAIL load_en_tc: tc=%b want 0", tc);
    end
    tick();
    n_vec++;
    if (q !== 8'd3 || wrap !== 1'b0 || load_err !== 1'b0) begin
      n_err++;
      $display("FAIL load_en: q=%0d wrap=%b lerr=%b want 3 0 0", q, wrap, load_err);
    end
  endtask

  task automatic test_reset_pending();
    do_reset();
    set_in(0, 1, 1, 0, 0, 1, 3);
    tick();
    set_in(0, 1, 1, 0, 0, 0, 0);
    tick();
    do_reset();
    n_vec++;
    if (q !== 8'd0 || mod_pending !== 1'b0 || mod_active !== 8'd9 || wrap !== 1'b0) begin
      n_err++;
      $display("FAIL reset_pend: q=%0d pend=%b act=%0d wrap=%b want 0 0 9 0", q, mod_pending, mod_active, wrap);
    end
    // the discarded shadow must not surface at the next wrap
    for (int i = 0; i < 10; i++) begin
      set_in(0, 1, 1, 0, 0, 0, 0);
      tick();
    end
    n_vec++;
    if (mod_active !== 8'd9 || q !== 8'd0) begin
      n_err++;
      $display("FAIL reset_shadow: act=%0d q=%0d want 9 0", mod_active, q);
    end
  endtask

  task automatic test_mod_zero();
    do_reset();
    set_in(0, 1, 0, 0, 0, 1, 0);
    tick();
    for (int i = 0; i < 6; i++) begin
      set_in(0, 1, i[0], 0, 0, 0, 0);
      n_vec++;
      if (tc !== 1'b1) begin
        n_err++;
        $display("FAIL mod0_tc %0d: tc=%b want 1", i, tc);
      end
      tick();
      n_vec++;
      if (q !== 8'd0 || wrap !== 1'b1 || mod_active !== 8'd0) begin
        n_err++;
        $display("FAIL mod0 %0d: q=%0d wrap=%b act=%0d want 0 1 0", i, q, wrap, mod_active);
      end
    end
  endtask

  task automatic test_random();
    bit rst, en, ud, ld, mw;
    int lv, mv;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      ld  = ($urandom_range(0, 7) == 0);
      en  = ($urandom_range(0, 3) != 0);
      ud  = $urandom_range(0, 1);
      mw  = ($urandom_range(0, 9) == 0);
      mv  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12);
      lv  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 15);
      set_in(rst, en, ud, ld, lv, mw, mv);
      n_vec++;
      if (tc !== model_tc()) begin
        n_err++;
        $display("FAIL rnd_tc %0d: tc=%b want %b", i, tc, model_tc());
      end
      tick();
      n_vec++;
      if (q !== 8'(m_q) || wrap !== m_wrap || load_err !== m_lerr ||
          mod_active !== 8'(m_act) || mod_pending !== m_pend) begin
        n_err++;
        $display("FAIL rnd %0d: q=%0d wrap=%b lerr=%b act=%0d pend=%b want %0d %b %b %0d %b",
                 i, q, wrap, load_err, mod_active, mod_pending, m_q, m_wrap, m_lerr, m_act, m_pend);
      end
    end
  endtask

  initial begin
    m_q = 0; m_act = DEF; m_sh = DEF; m_pend = 0; m_wrap = 0; m_lerr = 0;
    set_in(1, 0, 1, 0, 0, 0, 0);
    tick();
    test_reset();
    test_count_up();
    test_count_down();
    test_mod_buffered();
    test_mod_bypass();
    test_load_clamp();
    test_load_over_enable();
    test_reset_pending();
    test_mod_zero();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
